// File: rtl/data_mem_responder_pkg.sv
// Shared defines for the core's memory path.
// Holds the instruction-field positions used by the decoder, the access-size
// encoding (identical to the core's SaveMethod field), and the state encoding
// of the data-memory responder FSM.
package data_mem_responder_pkg;

  // Instruction-field positions (RV32 base encoding).
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned REG_IDX_W  = 5;

  // Memory access width, same bit pattern as SaveMethod.
  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_e;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } resp_state_e;

endpackage

// File: rtl/data_mem_responder_lane.sv
// data_lane_align: combinational lane handling for the data memory.
//   size        : access width (mem_size_e encoding)
//   is_unsigned : load zero-extend (1) or sign-extend (0); ignored for words
//   lane        : byte offset addr[1:0] within the addressed word
//   mem_word    : current contents of the addressed word
//   wdata       : right-aligned store data
//   store_word  : mem_word with the addressed lanes replaced by wdata
//   load_data   : addressed lanes extracted and extended to 32 bits
module data_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  function automatic logic [31:0] extend8(input logic [7:0] v, input logic zext);
    return zext ? {24'd0, v} : {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] extend16(input logic [15:0] v, input logic zext);
    return zext ? {16'd0, v} : {{16{v[15]}}, v};
  endfunction

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    store_word = mem_word;
    load_data  = '0;
    byte_v     = mem_word[{lane, 3'b000} +: 8];
    half_v     = mem_word[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: begin
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
        load_data = extend8(byte_v, is_unsigned);
      end
      SIZE_HALF: begin
        store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        load_data = extend16(half_v, is_unsigned);
      end
      SIZE_WORD: begin
        store_word = wdata;
        load_data  = mem_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port data memory with a fixed number of wait
// states, answering one core load/store at a time.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata, rsp_err  : extended load data / rejection flag, held until
//                         the next access
//   busy                : responder not idle (core stall)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  resp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        we_p0, uns_p0;
  logic [1:0]  size_p0;
  logic [31:0] addr_p0, wdata_p0;
  logic [31:0] rdata_p1;
  logic        err_p1;

  logic [31:0] mem [DEPTH_WORDS];

  logic        in_idle, accept, access;
  logic        acc_we, acc_uns, acc_err;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr, acc_wdata;
  logic [AW-1:0] word_idx;
  logic [31:0] mem_word, store_word, load_data;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && req_valid;

  // With zero wait states the access happens on the acceptance edge and must
  // use the live request; otherwise it uses the latched copy.
  assign access = in_idle ? (req_valid && (WAIT_CYCLES == 0))
                          : ((state_q == WAIT) && (cnt_q == 4'd0));

  always_comb begin
    acc_we    = in_idle ? req_we       : we_p0;
    acc_size  = in_idle ? req_size     : size_p0;
    acc_uns   = in_idle ? req_unsigned : uns_p0;
    acc_addr  = in_idle ? req_addr     : addr_p0;
    acc_wdata = in_idle ? req_wdata    : wdata_p0;
  end

  always_comb begin
    acc_err = ({2'b00, acc_addr[31:2]} >= DEPTH_WORDS);
    case (acc_size)
      SIZE_HALF:    if (acc_addr[0]) acc_err = 1'b1;
      SIZE_WORD:    if (acc_addr[1:0] != 2'b00) acc_err = 1'b1;
      SIZE_ILLEGAL: acc_err = 1'b1;
      default: ;
    endcase
  end

  assign word_idx = acc_addr[AW+1:2];
  assign mem_word = mem[word_idx];

  data_lane_align u_lane (
    .size        (acc_size),
    .is_unsigned (acc_uns),
    .lane        (acc_addr[1:0]),
    .mem_word    (mem_word),
    .wdata       (acc_wdata),
    .store_word  (store_word),
    .load_data   (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        rdata_p1 <= (acc_err || acc_we) ? 32'd0 : load_data;
        err_p1   <= acc_err;
      end
    end
  end

  // p0: request captured at acceptance, frozen for the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // Storage is never reset; a reset on the access edge cancels the commit.
  always_ff @(posedge clk) begin
    if (!rst && access && acc_we && !acc_err) begin
      mem[word_idx] <= store_word;
    end
  end

  assign req_ready = in_idle;
  assign busy      = !in_idle;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_p1;
  assign rsp_err   = err_p1;

endmodule
